// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore control FSM that steps a multicycle RV32I datapath
//                through fetch/decode/execute/memory/writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       illegal
);

    localparam logic [6:0] c_opLoad   = 7'b0000011;
    localparam logic [6:0] c_opStore  = 7'b0100011;
    localparam logic [6:0] c_opRType  = 7'b0110011;
    localparam logic [6:0] c_opIType  = 7'b0010011;
    localparam logic [6:0] c_opBranch = 7'b1100011;
    localparam logic [6:0] c_opJal    = 7'b1101111;
    localparam logic [6:0] c_opJalr   = 7'b1100111;
    localparam logic [6:0] c_opLui    = 7'b0110111;
    localparam logic [6:0] c_opAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JALRADR  = 4'd9,
        S_JUMP     = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_ALUWB    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_ready;

    assign w_ready = WAIT_MEM ? mem_ready : 1'b1;
    assign illegal = r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_opLoad, c_opStore: w_next = S_MEMADR;
                    c_opRType:           w_next = S_EXECR;
                    c_opIType:           w_next = S_EXECI;
                    c_opBranch:          w_next = S_BRANCH;
                    c_opJal:             w_next = S_JUMP;
                    c_opJalr:            w_next = S_JALRADR;
                    c_opLui:             w_next = S_LUI;
                    c_opAuipc:           w_next = S_AUIPC;
                    default:             w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_BRANCH:   w_next = S_FETCH;
            S_JALRADR:  w_next = S_JUMP;
            S_JUMP:     w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            c_opStore:          ImmSrc = 3'b001;
            c_opBranch:         ImmSrc = 3'b010;
            c_opJal:            ImmSrc = 3'b011;
            c_opLui, c_opAuipc: ImmSrc = 3'b100;
            default:            ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_ready;
                PCUpdate  = w_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR, S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = w_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
                retire  = 1'b1;
            end
            // PC takes the target while ALU forms OldPC+4 for the link write
            S_JUMP: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore control FSM that sequences a multicycle RV32I datapath: one shared ALU, a unified instruction/data memory port, and IR/OldPC/A/ALUOut/Data holding registers.
- Replaces the single-cycle opcode decoder in the multicycle core variant.
- Steps each instruction through fetch, decode, execute, memory and writeback states, stalling on a memory-ready handshake.

Parameters:
- WAIT_MEM, 1, 1 = honour mem_ready in FETCH/MEMREAD/MEMWRITE; 0 = treat mem_ready as constant 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces FETCH.
- op  input  7  opcode field of the IR (valid from DECODE onward).
- mem_ready  input  1  memory completes the current access this cycle.
- PCUpdate  output  1  load PC from the result bus.
- Branch  output  1  load PC if the ALU branch condition holds.
- IRWrite  output  1  load IR and OldPC.
- RegWrite  output  1  register file write.
- MemWrite  output  1  memory write request.
- AdrSrc  output  1  0 = PC, 1 = ALUOut drives the memory address.
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 A (rs1), 11 zero.
- ALUSrcB  output  2  00 B (rs2), 01 imm, 10 constant 4.
- ALUOp  output  2  00 add, 01 branch compare, 10 funct-decoded.
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
- retire  output  1  one-cycle pulse when the instruction completes.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- State register: 4-bit; async reset to FETCH. All control outputs are combinational from state; stall-qualified outputs are also gated by mem_ready.
- Reset value, every output: IRWrite, PCUpdate, ALUSrcA=00, ALUSrcB=10, ResultSrc=10 (FETCH values) as below; all other 1-bit outputs 0, ALUOp=00, AdrSrc=0; illegal=0, retire=0.
- Unlisted outputs are 0 in every state.
- ImmSrc is combinational from op in every state:
  - lw, I-ALU, jalr → 000; sw → 001; branch → 010; jal → 011; lui, auipc → 100; others → 000.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - 1100111 → JALRADR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00; hold while mem_ready=0; then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1; next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1. On the ready cycle retire=1 and next state is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1; next FETCH.
- JALRADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next JUMP.
- JUMP: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 (PC←target, ALUOut←OldPC+4); next ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; next ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1; next FETCH.
- TRAP: all enables 0. illegal is set on entry and stays 1 until reset; the FSM stays in TRAP.
- Cycle counts with zero wait states: beq 3; R, I, sw, jal, lui, auipc 4; lw, jalr 5. Each mem_ready=0 cycle adds one cycle.
- Exactly one retire pulse per completed instruction; none in TRAP.
- Reset mid-instruction: state returns to FETCH at once; no RegWrite/MemWrite pulse completes; illegal clears.
- Unused state encodings go to FETCH.

Test Plan:
- Reset asserted mid-EXECR, mem_ready=1 → state FETCH immediately; RegWrite=0, MemWrite=0, illegal=0; IRWrite=1 and PCUpdate=1 in the first cycle after release.
- op=0110011, mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; ALUOp=10 in EXECR; RegWrite=1 and retire=1 only in cycle 4; back in FETCH in cycle 5.
- op=0000011, mem_ready low for 2 cycles during MEMREAD → 7 cycles total; AdrSrc=1 for 3 cycles; RegWrite=1 with ResultSrc=01 in MEMWB only.
- op=0100011 with mem_ready=0 for 3 cycles in MEMWRITE → MemWrite high for 4 consecutive cycles; retire pulses once on the ready cycle; ImmSrc=001.
- op=1100111 → FETCH, DECODE, JALRADR, JUMP, ALUWB; PCUpdate=1 in FETCH and JUMP only; ImmSrc=000.
- op=1111111 → TRAP after DECODE; illegal=1 held for 10+ cycles, no enables, no retire; reset clears illegal and returns to FETCH.
